// File: rtl/wallace_tree_reduction_6bit_core_if.sv
// Operand/result bundle for the 6x6 Wallace-tree multiplier core.
// The master drives operands; the slave (the core) returns sum, carry and result.
interface wallace_tree_reduction_6bit_core_if;
    logic [5:0]  A;
    logic [5:0]  B;
    logic        CIN;
    logic [15:0] sum;
    logic        carry;
    logic [16:0] result;

    modport master (
        output A, B, CIN,
        input  sum, carry, result
    );

    modport slave (
        input  A, B, CIN,
        output sum, carry, result
    );
endinterface

// File: rtl/wallace_tree_reduction_6bit_core.sv
// 3-stage pipelined 6x6 unsigned multiplier with carry-in: operand register,
// Wallace-tree reduction to two rows, then a 16-bit carry-propagate adder.
module wallace_tree_reduction_6bit_core (
    input  logic                               clk,
    input  logic                               rst_n,
    wallace_tree_reduction_6bit_core_if.slave  bus
);

    typedef logic [15:0][7:0] col_t;
    typedef logic [15:0][3:0] hgt_t;

    function automatic logic bit_at(input logic [7:0] v, input int k);
        logic [7:0] t;
        t = v >> k;
        return t[0];
    endfunction

    // One Wallace level: each column is consumed in groups of three (full
    // adder), a leftover pair goes to a half adder and a single bit passes.
    // Sums stay in their column, carries are appended to the next column.
    function automatic void reduce_level(
        input  col_t m,
        input  hgt_t h,
        output col_t mo,
        output hgt_t ho
    );
        int   cnt [16];
        int   n;
        int   k;
        logic x;
        logic y;
        logic z;
        logic s;
        logic co;
        mo = '0;
        ho = '0;
        for (int c = 0; c < 16; c++) cnt[c] = 0;
        for (int c = 0; c < 16; c++) begin
            n = int'(h[c]);
            k = 0;
            for (int f = 0; f < 3; f++) begin
                if (n - k >= 3) begin
                    x  = bit_at(m[c], k);
                    y  = bit_at(m[c], k + 1);
                    z  = bit_at(m[c], k + 2);
                    s  = x ^ y ^ z;
                    co = (x & y) | (x & z) | (y & z);
                    mo[c] = mo[c] | (8'(s) << cnt[c]);
                    cnt[c] = cnt[c] + 1;
                    if (c < 15) begin
                        mo[c + 1] = mo[c + 1] | (8'(co) << cnt[c + 1]);
                        cnt[c + 1] = cnt[c + 1] + 1;
                    end
                    k = k + 3;
                end
            end
            if (n - k == 2) begin
                x  = bit_at(m[c], k);
                y  = bit_at(m[c], k + 1);
                s  = x ^ y;
                co = x & y;
                mo[c] = mo[c] | (8'(s) << cnt[c]);
                cnt[c] = cnt[c] + 1;
                if (c < 15) begin
                    mo[c + 1] = mo[c + 1] | (8'(co) << cnt[c + 1]);
                    cnt[c + 1] = cnt[c + 1] + 1;
                end
            end else if (n - k == 1) begin
                x = bit_at(m[c], k);
                mo[c] = mo[c] | (8'(x) << cnt[c]);
                cnt[c] = cnt[c] + 1;
            end
        end
        for (int c = 0; c < 16; c++) ho[c] = 4'(cnt[c]);
    endfunction

    // Partial products and three reduction levels: heights 6 -> 4 -> 3 -> 2.
    function automatic void wallace_rows(
        input  logic [5:0]  a,
        input  logic [5:0]  b,
        output logic [15:0] s_row,
        output logic [15:0] c_row
    );
        col_t m0;
        col_t m1;
        col_t m2;
        col_t m3;
        hgt_t h0;
        hgt_t h1;
        hgt_t h2;
        hgt_t h3;
        int   cnt [16];
        m0 = '0;
        h0 = '0;
        for (int w = 0; w < 16; w++) cnt[w] = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                m0[i + j] = m0[i + j] | (8'(a[j] & b[i]) << cnt[i + j]);
                cnt[i + j] = cnt[i + j] + 1;
            end
        end
        for (int w = 0; w < 16; w++) h0[w] = 4'(cnt[w]);
        reduce_level(m0, h0, m1, h1);
        reduce_level(m1, h1, m2, h2);
        reduce_level(m2, h2, m3, h3);
        s_row = '0;
        c_row = '0;
        for (int w = 0; w < 16; w++) begin
            s_row[w] = bit_at(m3[w], 0) & (h3[w] > 4'd0);
            c_row[w] = bit_at(m3[w], 1) & (h3[w] > 4'd1);
        end
    endfunction

    logic [5:0]  a_p0;
    logic [5:0]  b_p0;
    logic        cin_p0;
    logic [15:0] s_row;
    logic [15:0] c_row;
    logic [15:0] s_p1;
    logic [15:0] c_p1;
    logic        cin_p1;
    logic [16:0] cpa;
    logic [15:0] sum_p2;
    logic        carry_p2;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0   <= '0;
            b_p0   <= '0;
            cin_p0 <= 1'b0;
        end else begin
            a_p0   <= bus.A;
            b_p0   <= bus.B;
            cin_p0 <= bus.CIN;
        end
    end

    always_comb begin
        s_row = '0;
        c_row = '0;
        wallace_rows(a_p0, b_p0, s_row, c_row);
    end

    // Stage 2: reduced rows and delayed carry-in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_p1   <= '0;
            c_p1   <= '0;
            cin_p1 <= 1'b0;
        end else begin
            s_p1   <= s_row;
            c_p1   <= c_row;
            cin_p1 <= cin_p0;
        end
    end

    assign cpa = 17'(s_p1) + 17'(c_p1) + 17'(cin_p1);

    // Stage 3: final carry-propagate sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p2   <= '0;
            carry_p2 <= 1'b0;
        end else begin
            sum_p2   <= cpa[15:0];
            carry_p2 <= cpa[16];
        end
    end

    assign bus.sum    = sum_p2;
    assign bus.carry  = carry_p2;
    assign bus.result = {carry_p2, sum_p2};

endmodule

// File: tb/tb_wallace_tree_reduction_6bit_core.sv
// Scoreboard bench for the pipelined Wallace-tree multiplier: expected A*B+CIN
// values are queued at drive time and compared three edges later.
module tb_wallace_tree_reduction_6bit_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    wallace_tree_reduction_6bit_core_if bus();

    wallace_tree_reduction_6bit_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_out(input string tag, input logic [16:0] e);
        checks++;
        assert (bus.result === e) else begin
            errors++;
            $error("FAIL %s result observed=%0d expected=%0d", tag, bus.result, e);
        end
        checks++;
        assert (bus.sum === e[15:0]) else begin
            errors++;
            $error("FAIL %s sum observed=%0d expected=%0d", tag, bus.sum, e[15:0]);
        end
        checks++;
        assert (bus.carry === e[16]) else begin
            errors++;
            $error("FAIL %s carry observed=%0b expected=%0b", tag, bus.carry, e[16]);
        end
    endtask

    task automatic push_exp(input logic [16:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    // One clock per call: compare the oldest in-flight result, then drive new operands.
    task automatic step(input logic [5:0] a, input logic [5:0] b, input logic c, input string tag);
        exp_t x;
        int   r;
        @(negedge clk);
        if (q.size() == 3) begin
            x = q.pop_front();
            check_out(x.tag, x.v);
        end
        bus.A   = a;
        bus.B   = b;
        bus.CIN = c;
        r = int'(a) * int'(b) + int'(c);
        push_exp(17'(r), tag);
    endtask

    // Inputs are zero at release, so the first three outputs after release must be zero.
    task automatic release_reset;
        bus.A   = '0;
        bus.B   = '0;
        bus.CIN = 1'b0;
        @(negedge clk);
        check_out("hold_before_release", 17'd0);
        rst_n = 1'b1;
        q.delete();
        repeat (3) push_exp(17'd0, "post_release");
    endtask

    task automatic mid_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_clear", 17'd0);
        bus.A   = 6'd63;
        bus.B   = 6'd63;
        bus.CIN = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_out("hold_in_reset", 17'd0);
        end
        release_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.A   = 6'd45;
        bus.B   = 6'd33;
        bus.CIN = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_out("reset_immediate", 17'd0);
        repeat (3) @(negedge clk);
        check_out("reset_state", 17'd0);
        release_reset();

        step(6'd27, 6'd46, 1'b0, "a27_b46");
        step(6'd27, 6'd10, 1'b0, "a27_b10");
        step(6'd63, 6'd63, 1'b1, "max_cin");
        step(6'd0,  6'd37, 1'b1, "zero_a_cin");
        step(6'd63, 6'd0,  1'b0, "zero_b");
        step(6'd1,  6'd1,  1'b0, "one_one");
        step(6'd45, 6'd21, 1'b1, "a45_b21");
        step(6'd42, 6'd21, 1'b0, "alt_bits");
        step(6'd63, 6'd62, 1'b1, "near_max");

        mid_reset();

        step(6'd5,  6'd7,  1'b1, "after_reset_1");
        step(6'd12, 6'd34, 1'b0, "after_reset_2");
        step(6'd63, 6'd63, 1'b0, "after_reset_max");

        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 64; a++) begin
                for (int b = 0; b < 64; b++) begin
                    step(6'(a), 6'(b), 1'(c), "sweep");
                end
            end
        end

        repeat (3) step(6'd0, 6'd0, 1'b0, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
